// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between a requester and the data memory controller.
// The requester drives the request fields; the controller answers with a
// registered ready pulse, the load result and an error flag.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed, big-endian data memory with a fixed-latency request/ready
// handshake. One access is outstanding at a time; the request is latched on
// acceptance, waits LATENCY cycles, and completes with a one-cycle ready pulse
// carrying the load data or an error (bad size, misalignment, out of range).
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 64,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  // Wide enough for addr + 4 without wrapping and for DEPTH_BYTES itself.
  localparam int CHK_W = ((ADDR_W > 17) ? ADDR_W : 17) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic              accept_s;

  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [1:0]        size_r;
  logic              sext_r;
  logic [31:0]       wdata_r;

  logic [31:0]       rdata_r;
  logic              ready_r;
  logic              err_r;

  logic [7:0]        mem [DEPTH_BYTES];

  logic [IDX_W-1:0]  idx0_s;
  logic [IDX_W-1:0]  idx1_s;
  logic [IDX_W-1:0]  idx2_s;
  logic [IDX_W-1:0]  idx3_s;
  logic [CHK_W-1:0]  nbytes_s;
  logic [CHK_W-1:0]  end_s;
  logic              align_err_s;
  logic              range_err_s;
  logic              size_err_s;
  logic              err_s;
  logic              wr_en_s;
  logic [31:0]       load_s;

  // Next-state and wait-counter logic; request is sampled only in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          accept_s = 1'b1;
          if (LATENCY == 0) begin
            state_nxt_s = DONE;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = 4'(LATENCY);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = DONE;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State register, wait counter and request capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sext_r  <= 1'b0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        addr_r  <= bus.addr;
        we_r    <= bus.we;
        size_r  <= bus.size;
        sext_r  <= bus.sign_ext;
        wdata_r <= bus.wdata;
      end
    end
  end

  assign idx0_s = addr_r[IDX_W-1:0];
  assign idx1_s = idx0_s + IDX_W'(1);
  assign idx2_s = idx0_s + IDX_W'(2);
  assign idx3_s = idx0_s + IDX_W'(3);

  // Access checks on the latched request: size code, alignment and bounds.
  always_comb begin
    nbytes_s    = CHK_W'(4);
    align_err_s = 1'b0;
    size_err_s  = 1'b0;
    case (size_r)
      2'b00: nbytes_s = CHK_W'(1);
      2'b01: begin
        nbytes_s    = CHK_W'(2);
        align_err_s = addr_r[0];
      end
      2'b10: begin
        nbytes_s    = CHK_W'(4);
        align_err_s = (addr_r[1:0] != 2'b00);
      end
      default: size_err_s = 1'b1;
    endcase
    end_s       = CHK_W'(addr_r) + nbytes_s;
    range_err_s = (end_s > CHK_W'(DEPTH_BYTES));
    err_s       = size_err_s | align_err_s | range_err_s;
    wr_en_s     = (state_r == DONE) & we_r & ~err_s;
  end

  // Big-endian load assembly with optional sign extension.
  always_comb begin
    load_s = 32'd0;
    case (size_r)
      2'b00:   load_s = {{24{sext_r & mem[idx0_s][7]}}, mem[idx0_s]};
      2'b01:   load_s = {{16{sext_r & mem[idx0_s][7]}}, mem[idx0_s], mem[idx1_s]};
      2'b10:   load_s = {mem[idx0_s], mem[idx1_s], mem[idx2_s], mem[idx3_s]};
      default: load_s = 32'd0;
    endcase
  end

  // Storage update on a successful store; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      case (size_r)
        2'b00: mem[idx0_s] <= wdata_r[7:0];
        2'b01: begin
          mem[idx0_s] <= wdata_r[15:8];
          mem[idx1_s] <= wdata_r[7:0];
        end
        2'b10: begin
          mem[idx0_s] <= wdata_r[31:24];
          mem[idx1_s] <= wdata_r[23:16];
          mem[idx2_s] <= wdata_r[15:8];
          mem[idx3_s] <= wdata_r[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Completion outputs: ready pulse, error flag and held load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ready_r <= (state_r == DONE);
      if (state_r == DONE) begin
        err_r <= err_s;
        if (err_s) begin
          rdata_r <= 32'd0;
        end else if (!we_r) begin
          rdata_r <= load_s;
        end
      end else begin
        err_r <= 1'b0;
      end
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign bus.busy  = (state_r != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances (LATENCY 1, 0, 3) share
// the request fields; each has its own req. Expected completions are queued
// when a request is driven and popped when the matching ready pulse appears.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a [3];
  logic        we_i;
  logic [1:0]  size_i;
  logic        sext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_a [3];
  logic        ready_a [3];
  logic        busy_a [3];
  logic        err_a [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] hold_rd [3];

  typedef struct {
    int          sel;
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_ctrl_if #(.ADDR_W(32)) bus ();
    data_mem_ctrl #(
      .DEPTH_BYTES(64),
      .ADDR_W     (32),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
    assign bus.req      = req_a[g];
    assign bus.we       = we_i;
    assign bus.size     = size_i;
    assign bus.sign_ext = sext_i;
    assign bus.addr     = addr_i;
    assign bus.wdata    = wdata_i;
    assign rdata_a[g]   = bus.rdata;
    assign ready_a[g]   = bus.ready;
    assign busy_a[g]    = bus.busy;
    assign err_a[g]     = bus.err;
  end

  always #5 clk = ~clk;

  // Cycle counter used to time ready pulses against acceptance.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int s);
    case (s)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every ready pulse; err must be low otherwise.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      if (ready_a[s] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("ready_inst", 32'(s), 32'(e.sel));
          check_val("rdata", rdata_a[s], e.rd);
          check_val("err", {31'd0, err_a[s]}, {31'd0, e.err});
          check_val("ready_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        check_val("err_while_idle", {31'd0, err_a[s]}, 32'd0);
      end
    end
  end

  // Drive a request at the current negedge and queue its expected completion.
  task automatic start(input int s, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    we_i    = w;
    size_i  = sz;
    sext_i  = sx;
    addr_i  = a;
    wdata_i = wd;
    req_a[s] = 1'b1;
    e.sel = s;
    e.err = exp_err;
    e.rd  = (w && !exp_err) ? hold_rd[s] : exp_rd;
    hold_rd[s] = e.rd;
    e.due = cyc + lat_of(s) + 2;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic op(input int s, input logic w, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    start(s, w, sz, sx, a, wd, exp_rd, exp_err);
    @(negedge clk);
    req_a[s] = 1'b0;
    wait_done();
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      req_a[s]   = 1'b0;
      hold_rd[s] = 32'd0;
    end
    we_i = 1'b0; size_i = SZ_B; sext_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_val("rst_rdata", rdata_a[s], 32'd0);
      check_val("rst_ready", {31'd0, ready_a[s]}, 32'd0);
      check_val("rst_busy", {31'd0, busy_a[s]}, 32'd0);
    end
    rst_n = 1'b1;

    // LATENCY=1: store/load, extension, errors, byte merge.
    op(0, 1'b1, SZ_W, 1'b0, 32'h08, 32'h12345678, 32'd0, 1'b0);
    op(0, 1'b0, SZ_B, 1'b0, 32'h08, 32'd0, 32'h00000012, 1'b0);
    op(0, 1'b0, SZ_B, 1'b0, 32'h0B, 32'd0, 32'h00000078, 1'b0);
    op(0, 1'b1, SZ_B, 1'b0, 32'h0C, 32'h00000080, 32'd0, 1'b0);
    op(0, 1'b0, SZ_B, 1'b1, 32'h0C, 32'd0, 32'hFFFFFF80, 1'b0);
    op(0, 1'b0, SZ_B, 1'b0, 32'h0C, 32'd0, 32'h00000080, 1'b0);
    op(0, 1'b0, SZ_H, 1'b0, 32'h0A, 32'd0, 32'h00005678, 1'b0);
    op(0, 1'b0, SZ_W, 1'b1, 32'h08, 32'd0, 32'h12345678, 1'b0);
    op(0, 1'b1, SZ_H, 1'b0, 32'h10, 32'h0000F00D, 32'd0, 1'b0);
    op(0, 1'b0, SZ_H, 1'b1, 32'h10, 32'd0, 32'hFFFFF00D, 1'b0);
    op(0, 1'b0, SZ_H, 1'b0, 32'h10, 32'd0, 32'h0000F00D, 1'b0);
    op(0, 1'b1, SZ_W, 1'b0, 32'h3C, 32'hCAFEF00D, 32'd0, 1'b0);
    op(0, 1'b0, SZ_W, 1'b0, 32'h06, 32'd0, 32'd0, 1'b1);
    op(0, 1'b1, SZ_H, 1'b0, 32'h11, 32'h0000BEEF, 32'd0, 1'b1);
    op(0, 1'b1, SZ_W, 1'b0, 32'h3D, 32'h99999999, 32'd0, 1'b1);
    op(0, 1'b0, SZ_X, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
    op(0, 1'b0, SZ_B, 1'b0, 32'h40, 32'd0, 32'd0, 1'b1);
    op(0, 1'b1, SZ_W, 1'b0, 32'hFFFFFFFC, 32'h77777777, 32'd0, 1'b1);
    op(0, 1'b0, SZ_H, 1'b0, 32'h10, 32'd0, 32'h0000F00D, 1'b0);
    op(0, 1'b0, SZ_W, 1'b0, 32'h3C, 32'd0, 32'hCAFEF00D, 1'b0);
    op(0, 1'b0, SZ_B, 1'b0, 32'h3F, 32'd0, 32'h0000000D, 1'b0);
    op(0, 1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, 32'd0, 1'b0);
    op(0, 1'b1, SZ_B, 1'b0, 32'h21, 32'h000000AA, 32'd0, 1'b0);
    op(0, 1'b0, SZ_W, 1'b0, 32'h20, 32'd0, 32'h11AA3344, 1'b0);

    // LATENCY=0: req held high for three accesses, inputs scrambled while busy.
    @(negedge clk);
    start(1, 1'b1, SZ_W, 1'b0, 32'h00, 32'hA5A5A5A5, 32'd0, 1'b0);
    @(negedge clk);
    check_val("b2b_busy", {31'd0, busy_a[1]}, 32'd1);
    addr_i = 32'h3C; wdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    start(1, 1'b1, SZ_W, 1'b0, 32'h04, 32'h5A5A5A5A, 32'd0, 1'b0);
    @(negedge clk);
    addr_i = 32'h38; wdata_i = 32'h0BADF00D;
    @(negedge clk);
    start(1, 1'b0, SZ_W, 1'b0, 32'h00, 32'd0, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    req_a[1] = 1'b0;
    wait_done();

    // LATENCY=0: req toggling with a different store while busy is ignored.
    @(negedge clk);
    start(1, 1'b1, SZ_B, 1'b0, 32'h08, 32'h00000011, 32'd0, 1'b0);
    @(negedge clk);
    req_a[1] = 1'b0;
    #2 req_a[1] = 1'b1; addr_i = 32'h00; size_i = SZ_W; wdata_i = 32'hFFFFFFFF;
    #1 req_a[1] = 1'b0;
    #1 req_a[1] = 1'b1;
    @(negedge clk);
    req_a[1] = 1'b0;
    wait_done();
    op(1, 1'b0, SZ_W, 1'b0, 32'h00, 32'd0, 32'hA5A5A5A5, 1'b0);
    op(1, 1'b0, SZ_W, 1'b0, 32'h04, 32'd0, 32'h5A5A5A5A, 1'b0);
    op(1, 1'b0, SZ_B, 1'b0, 32'h08, 32'd0, 32'h00000011, 1'b0);

    // LATENCY=3: reset during WAIT aborts the store and produces no ready.
    op(2, 1'b1, SZ_W, 1'b0, 32'h00, 32'h01020304, 32'd0, 1'b0);
    op(2, 1'b0, SZ_W, 1'b0, 32'h00, 32'd0, 32'h01020304, 1'b0);
    @(negedge clk);
    we_i = 1'b1; size_i = SZ_W; addr_i = 32'h00; wdata_i = 32'hDEADBEEF; req_a[2] = 1'b1;
    @(negedge clk);
    req_a[2] = 1'b0;
    check_val("wait_busy", {31'd0, busy_a[2]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req_a[2] = 1'b1;
    #1;
    check_val("async_rst_busy", {31'd0, busy_a[2]}, 32'd0);
    check_val("async_rst_rdata", rdata_a[2], 32'd0);
    repeat (3) @(negedge clk);
    check_val("rst_req_ignored", {31'd0, busy_a[2]}, 32'd0);
    req_a[2] = 1'b0;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) hold_rd[s] = 32'd0;
    repeat (5) @(negedge clk);
    check_val("post_rst_idle", {31'd0, busy_a[2]}, 32'd0);
    op(2, 1'b0, SZ_W, 1'b0, 32'h00, 32'd0, 32'h01020304, 1'b0);
    op(0, 1'b0, SZ_W, 1'b0, 32'h20, 32'd0, 32'h11AA3344, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 64: byte capacity of the storage array; legal range is 4..65536, multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 32: address port width.
REQ-003 SHALL have parameter LATENCY, default 1: wait cycles inserted between acceptance and completion; legal range is 0..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, 1: access request; sampled only in IDLE.
REQ-007 SHALL have port we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port size, input, 2: access size; 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 SHALL have port sign_ext, input, 1: on loads, 1 = sign-extend and 0 = zero-extend.
REQ-010 SHALL have port addr, input, ADDR_W: byte address.
REQ-011 SHALL have port wdata, input, 32: store data, right-justified.
REQ-012 SHALL have port rdata, output, 32: load result, registered.
REQ-013 SHALL have port ready, output, 1: one-cycle completion pulse, registered.
REQ-014 SHALL have port busy, output, 1: high while an accepted access is outstanding.
REQ-015 SHALL have port err, output, 1: error flag, valid only while ready=1.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and DONE; busy=1 in WAIT and DONE.
REQ-017 SHALL, in IDLE with req=1, latch addr, we, size, sign_ext and wdata at the rising edge and move to WAIT, or to DONE when LATENCY=0.
REQ-018 SHALL count exactly LATENCY cycles in WAIT with a 4-bit down-counter, then enter DONE.
REQ-019 SHALL, on the edge leaving DONE, return to IDLE, perform any store, update rdata/err, and pulse ready for exactly one cycle.
REQ-020 SHALL therefore raise ready LATENCY+1 cycles after the accepting edge.
REQ-021 SHALL allow a new req to be accepted in the cycle ready=1, giving back-to-back throughput of one access per LATENCY+2 cycles.
REQ-022 SHALL ignore req, and changes on all request inputs, while busy=1; only latched values are used.
REQ-023 SHALL store data big-endian: byte address a holds the most significant byte of the word at a.
REQ-024 SHALL load a byte as ram[a] into rdata[7:0], with rdata[31:8] extended per sign_ext from bit 7.
REQ-025 SHALL load a halfword as {ram[a],ram[a+1]} into rdata[15:0], with rdata[31:16] extended per sign_ext from bit 15.
REQ-026 SHALL load a word as {ram[a],ram[a+1],ram[a+2],ram[a+3]}; sign_ext is ignored.
REQ-027 SHALL store a byte as wdata[7:0] to ram[a].
REQ-028 SHALL store a halfword as wdata[15:8] to ram[a] and wdata[7:0] to ram[a+1].
REQ-029 SHALL store a word as wdata[31:24] through wdata[7:0] to ram[a] through ram[a+3].
REQ-030 SHALL leave unaddressed bytes unchanged on every store.
REQ-031 SHALL raise err with ready, with no store and rdata=0, when size=11.
REQ-032 SHALL raise err with ready, with no store and rdata=0, on a misaligned halfword (a[0]=1) or a misaligned word (a[1:0]!=00).
REQ-033 SHALL raise err with ready, with no store and rdata=0, when a+bytes > DEPTH_BYTES; this check uses full ADDR_W width and no wrap-around.
REQ-034 SHALL hold rdata after a successful store and between accesses, changing it only on a successful load or on an error.
REQ-035 SHALL keep err=0 whenever ready=0.

Reset
REQ-036 SHALL, while rst_n=0, immediately force IDLE, counter=0, ready=0, err=0, busy=0 and rdata=0.
REQ-037 SHALL NOT clear or alter storage contents on reset.
REQ-038 SHALL abort any outstanding access when reset is asserted mid-operation: no store is performed and no ready pulse is produced.
REQ-039 SHALL resume normal operation on the first rising edge after rst_n deasserts, with no spurious acceptance of a req held high during reset.

Verification
REQ-040 SHALL cover this store/load scenario with LATENCY=1: word store 0x12345678 at 0x08, then byte loads at 0x08 and 0x0B -> rdata 0x00000012 and 0x00000078; ready 2 cycles after each accept.
REQ-041 SHALL cover this extension scenario: halfword store 0x0000F00D at 0x10, then halfword load at 0x10 with sign_ext=1 -> 0xFFFFF00D, and with sign_ext=0 -> 0x0000F00D.
REQ-042 SHALL cover this error scenario: word load at 0x06, halfword store at 0x11, and word store at 0x3D with DEPTH_BYTES=64 -> err=1 with ready each time, rdata=0, and memory unchanged on readback.
REQ-043 SHALL cover this back-to-back scenario with LATENCY=0: req held high for 3 accesses -> ready pulses every 2 cycles, and req toggling while busy is ignored.
REQ-044 SHALL cover this mid-operation reset scenario: word store of 0xDEADBEEF at 0x00 with LATENCY=3, and rst_n low during WAIT -> no ready pulse, and a subsequent load at 0x00 returns the prior contents.
REQ-045 SHALL cover this byte-merge scenario: byte store 0xAA at 0x21 over word 0x11223344 at 0x20 -> word load at 0x20 returns 0x11AA3344.
